// File: rtl/response_distributor_if.sv
// Bundle of the upstream response channel and the per-requester return ports.
// The distributor sits on the slave side; the producer and consumers sit on the master side.
interface response_distributor_if #(
    parameter int NUM_REQUESTS                 = 3,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUESTS_LOG2            = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
);
    logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]              response_in;
    logic                                                 response_valid_in;
    logic [NUM_REQUESTS_LOG2-1:0]                         response_dest_in;
    logic                                                 issue_ack_out;
    logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUESTS-1:0] response_packed_out;
    logic [NUM_REQUESTS-1:0]                              response_valid_packed_out;
    logic [NUM_REQUESTS-1:0]                              issue_ack_packed_in;
    logic                                                 dest_error_out;

    modport master (
        output response_in, response_valid_in, response_dest_in, issue_ack_packed_in,
        input  issue_ack_out, response_packed_out, response_valid_packed_out, dest_error_out
    );

    modport slave (
        input  response_in, response_valid_in, response_dest_in, issue_ack_packed_in,
        output issue_ack_out, response_packed_out, response_valid_packed_out, dest_error_out
    );
endinterface

// File: rtl/response_distributor.sv
// Routes one response stream to NUM_REQUESTS requesters through a small FIFO per destination,
// so a stalled requester only blocks responses addressed to it.
module response_distributor #(
    parameter int NUM_REQUESTS                 = 3,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int FIFO_DEPTH                   = 2,
    parameter int NUM_REQUESTS_LOG2            = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
) (
    input logic                   clk_in,
    input logic                   reset_in,
    response_distributor_if.slave bus
);
    localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [NUM_REQUESTS_LOG2:0] NUM_REQ_EXT = (NUM_REQUESTS_LOG2 + 1)'(NUM_REQUESTS);

    logic [W-1:0]     storage [NUM_REQUESTS][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr  [NUM_REQUESTS];
    logic [PTR_W-1:0] rd_ptr  [NUM_REQUESTS];
    logic [CNT_W-1:0] count   [NUM_REQUESTS];
    logic             dest_error;

    logic [NUM_REQUESTS-1:0]   full;
    logic [NUM_REQUESTS-1:0]   empty;
    logic [NUM_REQUESTS-1:0]   push;
    logic [NUM_REQUESTS-1:0]   pop;
    logic                      dest_in_range;
    logic                      dest_full;
    logic                      accept;
    logic [W*NUM_REQUESTS-1:0] packed_data;

    assign dest_in_range = ({1'b0, bus.response_dest_in} < NUM_REQ_EXT);

    // Upstream ack looks only at registered occupancy, never at the consumer acks,
    // so a full port is refused even if it drains this same cycle.
    always_comb begin
        full      = '0;
        empty     = '0;
        pop       = '0;
        dest_full = 1'b0;
        for (int k = 0; k < NUM_REQUESTS; k++) begin
            full[k]  = (count[k] == CNT_W'(FIFO_DEPTH));
            empty[k] = (count[k] == '0);
            pop[k]   = ~empty[k] & bus.issue_ack_packed_in[k];
            if (bus.response_dest_in == NUM_REQUESTS_LOG2'(k)) begin
                dest_full = full[k];
            end
        end
    end

    assign accept = bus.response_valid_in & (~dest_in_range | ~dest_full);

    always_comb begin
        push = '0;
        for (int k = 0; k < NUM_REQUESTS; k++) begin
            push[k] = accept & dest_in_range &
                      (bus.response_dest_in == NUM_REQUESTS_LOG2'(k));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            dest_error <= 1'b0;
            for (int k = 0; k < NUM_REQUESTS; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            if (accept & ~dest_in_range) begin
                dest_error <= 1'b1;
            end
            for (int k = 0; k < NUM_REQUESTS; k++) begin
                if (push[k]) begin
                    storage[k][wr_ptr[k]] <= bus.response_in;
                    wr_ptr[k]             <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                case ({push[k], pop[k]})
                    2'b10:   count[k] <= count[k] + 1'b1;
                    2'b01:   count[k] <= count[k] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Empty ports present zero rather than stale storage contents.
    always_comb begin
        packed_data = '0;
        for (int k = 0; k < NUM_REQUESTS; k++) begin
            if (!empty[k]) begin
                packed_data[k*W +: W] = storage[k][rd_ptr[k]];
            end
        end
    end

    assign bus.issue_ack_out             = accept;
    assign bus.response_packed_out       = packed_data;
    assign bus.response_valid_packed_out = ~empty;
    assign bus.dest_error_out            = dest_error;
endmodule

// File: tb/tb_response_distributor.sv
// Directed bench for response_distributor: a table of single-cycle vectors followed by
// hand-written sequences for full/pop races, round-robin wrap, bad destinations and reset.
module tb_response_distributor;
    localparam int N  = 3;
    localparam int W  = 64;
    localparam int PW = N * W;

    typedef struct {
        logic          valid;
        logic [1:0]    dest;
        logic [W-1:0]  data;
        logic [N-1:0]  acks;
        logic          exp_ack;
        logic [N-1:0]  exp_valid;
        logic [PW-1:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    vec_t         vecs [14];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];
    int           sent_idx;

    response_distributor_if #(.NUM_REQUESTS(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W)) bus ();

    response_distributor #(
        .NUM_REQUESTS(N),
        .SINGLE_REQUEST_WIDTH_IN_BITS(W),
        .FIFO_DEPTH(2)
    ) dut (
        .clk_in(clk),
        .reset_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(input logic [W-1:0] p2, input logic [W-1:0] p1,
                                         input logic [W-1:0] p0);
        return {p2, p1, p0};
    endfunction

    task automatic check_output(input string name, input logic [PW-1:0] actual,
                                input logic [PW-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] dest,
                                  input logic [W-1:0] data, input logic [N-1:0] acks);
        bus.response_valid_in   = valid;
        bus.response_dest_in    = dest;
        bus.response_in         = data;
        bus.issue_ack_packed_in = acks;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Item 1: single entry to port 1, held five cycles, then drained.
        vecs[0]  = '{1'b1, 2'd1, 64'hA5, 3'b000, 1'b1, 3'b010, pk(0, 64'hA5, 0)};
        for (int i = 1; i <= 5; i++)
            vecs[i] = '{1'b0, 2'd0, 64'h0, 3'b000, 1'b0, 3'b010, pk(0, 64'hA5, 0)};
        vecs[6]  = '{1'b0, 2'd0, 64'h0, 3'b010, 1'b0, 3'b000, pk(0, 0, 0)};
        // Item 2: port 0 fills, third push refused, other port unaffected, then ordered drain.
        vecs[7]  = '{1'b1, 2'd0, 64'h11, 3'b000, 1'b1, 3'b001, pk(0, 0, 64'h11)};
        vecs[8]  = '{1'b1, 2'd0, 64'h22, 3'b000, 1'b1, 3'b001, pk(0, 0, 64'h11)};
        vecs[9]  = '{1'b1, 2'd0, 64'h33, 3'b000, 1'b0, 3'b001, pk(0, 0, 64'h11)};
        vecs[10] = '{1'b1, 2'd2, 64'h44, 3'b000, 1'b1, 3'b101, pk(64'h44, 0, 64'h11)};
        vecs[11] = '{1'b1, 2'd0, 64'h33, 3'b001, 1'b0, 3'b101, pk(64'h44, 0, 64'h22)};
        vecs[12] = '{1'b1, 2'd0, 64'h33, 3'b001, 1'b1, 3'b101, pk(64'h44, 0, 64'h33)};
        vecs[13] = '{1'b0, 2'd0, 64'h0, 3'b101, 1'b0, 3'b000, pk(0, 0, 0)};

        apply_stimulus(1'b0, 2'd0, 64'h0, 3'b000);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        check_output("reset_valid", PW'(bus.response_valid_packed_out), PW'(3'b000));
        check_output("reset_data", bus.response_packed_out, '0);
        check_output("reset_error", PW'(bus.dest_error_out), PW'(1'b0));
        check_output("reset_ack_idle", PW'(bus.issue_ack_out), PW'(1'b0));

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].dest, vecs[i].data, vecs[i].acks);
            check_output($sformatf("vec%0d_ack", i), PW'(bus.issue_ack_out), PW'(vecs[i].exp_ack));
            next_cycle();
            check_output($sformatf("vec%0d_valid", i), PW'(bus.response_valid_packed_out),
                         PW'(vecs[i].exp_valid));
            check_output($sformatf("vec%0d_data", i), bus.response_packed_out, vecs[i].exp_data);
        end

        // Full port 2 popping while a push arrives: refused once, then streaming with no loss.
        apply_stimulus(1'b1, 2'd2, 64'hB0, 3'b000);
        next_cycle();
        apply_stimulus(1'b1, 2'd2, 64'hB1, 3'b000);
        next_cycle();
        exp_q = '{64'hB0, 64'hB1};
        for (int i = 0; i < 8; i++) exp_q.push_back(64'hC0 + 64'(i));
        got_q.delete();
        sent_idx = 0;
        for (int cyc = 0; cyc < 40 && (sent_idx < 8 || got_q.size() < 10); cyc++) begin
            apply_stimulus(sent_idx < 8, 2'd2, 64'hC0 + 64'(sent_idx), 3'b100);
            if (cyc == 0) check_output("race_full_refused", PW'(bus.issue_ack_out), PW'(1'b0));
            if (cyc == 1) check_output("race_retry_accepted", PW'(bus.issue_ack_out), PW'(1'b1));
            if (bus.response_valid_packed_out[2]) got_q.push_back(bus.response_packed_out[2*W +: W]);
            if (bus.response_valid_in && bus.issue_ack_out) sent_idx++;
            next_cycle();
        end
        check_output("race_count", PW'(got_q.size()), PW'(10));
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check_output($sformatf("race_order%0d", i), PW'(got_q[i]), PW'(exp_q[i]));
        apply_stimulus(1'b0, 2'd0, 64'h0, 3'b000);
        check_output("race_drained", PW'(bus.response_valid_packed_out), PW'(3'b000));

        // Round-robin with all consumers acking: one-hot valid, wrap over 20 transfers.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 2'(i % 3), 64'hD00 + 64'(i), 3'b111);
            check_output($sformatf("rr%0d_ack", i), PW'(bus.issue_ack_out), PW'(1'b1));
            next_cycle();
            check_output($sformatf("rr%0d_valid", i), PW'(bus.response_valid_packed_out),
                         PW'(3'b001 << (i % 3)));
            check_output($sformatf("rr%0d_data", i), bus.response_packed_out,
                         PW'(64'hD00 + 64'(i)) << (W * (i % 3)));
        end
        apply_stimulus(1'b0, 2'd0, 64'h0, 3'b111);
        next_cycle();
        check_output("rr_drained", PW'(bus.response_valid_packed_out), PW'(3'b000));

        // Out-of-range destination: acked, dropped, sticky error.
        apply_stimulus(1'b1, 2'd3, 64'hEE, 3'b000);
        check_output("bad_dest_ack", PW'(bus.issue_ack_out), PW'(1'b1));
        next_cycle();
        check_output("bad_dest_valid", PW'(bus.response_valid_packed_out), PW'(3'b000));
        check_output("bad_dest_error", PW'(bus.dest_error_out), PW'(1'b1));
        apply_stimulus(1'b0, 2'd0, 64'h0, 3'b000);
        for (int i = 0; i < 3; i++) next_cycle();
        check_output("bad_dest_sticky", PW'(bus.dest_error_out), PW'(1'b1));

        // Reset with two entries buffered on port 1 discards them and clears the error.
        apply_stimulus(1'b1, 2'd1, 64'h55, 3'b000);
        next_cycle();
        apply_stimulus(1'b1, 2'd1, 64'h66, 3'b000);
        next_cycle();
        check_output("pre_reset_valid", PW'(bus.response_valid_packed_out), PW'(3'b010));
        apply_stimulus(1'b0, 2'd0, 64'h0, 3'b000);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check_output("mid_reset_valid", PW'(bus.response_valid_packed_out), PW'(3'b000));
        check_output("mid_reset_data", bus.response_packed_out, '0);
        check_output("mid_reset_error", PW'(bus.dest_error_out), PW'(1'b0));
        apply_stimulus(1'b1, 2'd1, 64'h77, 3'b000);
        check_output("post_reset_ack", PW'(bus.issue_ack_out), PW'(1'b1));
        next_cycle();
        check_output("post_reset_valid", PW'(bus.response_valid_packed_out), PW'(3'b010));
        check_output("post_reset_data", bus.response_packed_out, pk(0, 64'h77, 0));
        apply_stimulus(1'b0, 2'd0, 64'h0, 3'b010);
        next_cycle();
        check_output("post_reset_drained", PW'(bus.response_valid_packed_out), PW'(3'b000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/response_distributor.md
Name: response_distributor

Overview:
- Return-path counterpart of the request arbiter: takes one response stream from the shared downstream (cache/memory side) and routes each response to one of NUM_REQUESTS requesters by destination index.
- Each destination has a small FIFO, so one stalled requester blocks only responses addressed to it.
- Uses the same valid/ack handshake on both sides: a transfer occurs in any cycle where valid and ack are both high.

Parameters:
- NUM_REQUESTS, 3, number of destination ports.
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, width of one response payload.
- FIFO_DEPTH, 2, entries per destination FIFO; power of two, at least 2.
- NUM_REQUESTS_LOG2, derived as clog2(NUM_REQUESTS) with a minimum of 1; width of the destination field.

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous, active-high reset.
- response_in  input  SINGLE_REQUEST_WIDTH_IN_BITS  incoming response payload.
- response_valid_in  input  1  incoming response valid.
- response_dest_in  input  NUM_REQUESTS_LOG2  destination port index.
- issue_ack_out  output  1  incoming response accepted this cycle.
- response_packed_out  output  SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUESTS  per-port head data; port k occupies bits [(k+1)*W-1 : k*W].
- response_valid_packed_out  output  NUM_REQUESTS  per-port valid, high when that FIFO is non-empty.
- issue_ack_packed_in  input  NUM_REQUESTS  per-port consumer ack.
- dest_error_out  output  1  sticky flag: a response with out-of-range destination was seen.

Behaviour:
- Reset: one clock, synchronous, active-high, named reset_in.
  - All FIFO pointers and occupancy counters go to 0.
  - response_valid_packed_out = 0, response_packed_out = 0, dest_error_out = 0.
  - Reset in the middle of traffic discards all buffered entries; the cycle after reset, no port shows valid.
- Per-port FIFO state: write pointer, read pointer (each log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH) and an occupancy count of log2(FIFO_DEPTH)+1 bits. full = (count == FIFO_DEPTH); empty = (count == 0).
- Input acceptance (combinational):
  - issue_ack_out = response_valid_in & (dest out of range | ~full[response_dest_in]).
  - issue_ack_out depends only on registered full flags, never on issue_ack_packed_in. This means no combinational path from the consumer ack to the upstream ack.
  - A full destination is not acked even if it pops in the same cycle; the upstream holds the response and retries next cycle.
- Push: on a transfer (response_valid_in & issue_ack_out) with response_dest_in < NUM_REQUESTS:
  - write response_in at the write pointer of that port;
  - advance its write pointer;
  - the entry is visible on that port's outputs the next cycle (latency 1).
- Out-of-range destination (response_dest_in >= NUM_REQUESTS, possible when NUM_REQUESTS is not a power of two): the response is acked and discarded, and dest_error_out is set. dest_error_out clears only on reset.
- Output side, per port k:
  - response_valid_packed_out[k] = ~empty[k].
  - The data slice for port k is the FIFO entry at its read pointer while non-empty, and 0 while empty.
  - Pop occurs when valid[k] & issue_ack_packed_in[k]; the read pointer advances.
  - Ack on an empty port is ignored.
- Simultaneous push and pop on the same port: count is unchanged and both pointers advance. This is legal whenever the port is not full at the start of the cycle.
- Ports are independent: pops on any subset of ports can occur in the same cycle as one push.
- Ordering: responses to the same destination leave in arrival order. No ordering is guaranteed across destinations.
- Payload is passed through unmodified.

Test Plan:
- Reset, then push 0xA5 to dest 1 -> issue_ack_out = 1 in the same cycle; next cycle valid_packed = 3'b010 and slice 1 = 0xA5; hold ack_in[1] = 0 for 5 cycles -> data and valid stay stable; assert ack -> valid_packed = 3'b000 the following cycle.
- Fill port 0 with 0x11, 0x22 while ack_in = 0 -> full; a third push 0x33 to dest 0 gets issue_ack_out = 0 and is held. A push 0x44 to dest 2 in the next cycle gets issue_ack_out = 1. Release port 0 -> it outputs 0x11, 0x22, 0x33 in order.
- Port 2 full and ack_in[2] = 1 in the same cycle as an incoming push to dest 2 -> the pop happens, issue_ack_out = 0, and the push is accepted the next cycle; there are no duplicates or losses across 8 back-to-back pushes.
- Continuous round-robin pushes to dest 0, 1, 2, 0, ... with all acks high -> each port delivers one entry every 3 cycles with latency 1; pointers wrap correctly over 20 transfers.
- With NUM_REQUESTS = 3, push with dest 3 -> issue_ack_out = 1, no port becomes valid, dest_error_out = 1 and stays set until reset_in.
- Two entries buffered on port 1, assert reset_in for one cycle -> response_valid_packed_out = 0 the next cycle; a new push 0x77 to dest 1 then appears as the first entry on port 1.
